// File: rtl/dff_const_pipe_if.sv
// dff_const_pipe_if: shift-control and status bundle for dff_const_pipe.
//   en       shift enable
//   mode     0 = inject the constant, 1 = inject d
//   d        live data word
//   q        last pipeline stage
//   settled  all stages hold the same value
//   run_len  leading-run length (only with DFF_CONST_PIPE_RUNLEN_EN)
// Modports: master drives en/mode/d and observes status; slave is the pipeline.
interface dff_const_pipe_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic             mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             settled;
`ifdef DFF_CONST_PIPE_RUNLEN_EN
    logic [CNT_W-1:0] run_len;
`endif

    modport master (
        output en, mode, d,
        input  q, settled
`ifdef DFF_CONST_PIPE_RUNLEN_EN
        , input run_len
`endif
    );

    modport slave (
        input  en, mode, d,
        output q, settled
`ifdef DFF_CONST_PIPE_RUNLEN_EN
        , output run_len
`endif
    );
endinterface

// File: rtl/dff_const_pipe.sv
// dff_const_pipe: DEPTH-stage, WIDTH-bit register chain fed with either
// CONST_VAL (mode=0) or d (mode=1), with a registered flag showing that the
// whole chain holds one uniform value.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    dff_const_pipe_if.slave (en, mode, d in; q, settled, run_len out)
// Build option: DFF_CONST_PIPE_RUNLEN_EN exposes the run counter on run_len.
module dff_const_pipe #(
    parameter int unsigned           WIDTH     = 4,
    parameter int unsigned           DEPTH     = 4,
    parameter logic [WIDTH-1:0]      RST_VAL   = '0,
    parameter logic [WIDTH-1:0]      CONST_VAL = '1
) (
    input  logic            clk,
    input  logic            reset,
    dff_const_pipe_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] src;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settled_q, settled_d;

    // Run counter tracks how many leading stages match s[0]; it grows only
    // while the injected word repeats, saturating at DEPTH.
    always_comb begin
        src       = bus.mode ? bus.d : CONST_VAL;
        cnt_d     = ONE_C;
        settled_d = 1'b0;
        if (src == s_q[0]) begin
            cnt_d = (cnt_q == DEPTH_C) ? DEPTH_C : cnt_q + ONE_C;
        end
        settled_d = (cnt_d == DEPTH_C);
    end

    // Stage 0 and the status flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_q[0]    <= RST_VAL;
            cnt_q     <= DEPTH_C;
            settled_q <= 1'b1;
        end else if (bus.en) begin
            s_q[0]    <= src;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    // Remaining stages shift from their predecessor.
    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!reset) begin
                s_q[g] <= RST_VAL;
            end else if (bus.en) begin
                s_q[g] <= s_q[g-1];
            end
        end
    end

    assign bus.q       = s_q[DEPTH-1];
    assign bus.settled = settled_q;
`ifdef DFF_CONST_PIPE_RUNLEN_EN
    assign bus.run_len = cnt_q;
`endif
endmodule

// File: tb/tb_dff_const_pipe.sv
// tb_dff_const_pipe: directed bench for dff_const_pipe (DEPTH=4 and DEPTH=1
// instances side by side) with a history-based reference model.
module tb_dff_const_pipe;
    localparam int unsigned W  = 4;
    localparam int unsigned D  = 4;
    localparam logic [3:0]  RV = 4'h0;
    localparam logic [3:0]  CV = 4'hF;

    logic clk;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    dff_const_pipe_if #(.WIDTH(W), .DEPTH(D)) bus  ();
    dff_const_pipe_if #(.WIDTH(W), .DEPTH(1)) bus1 ();

    dff_const_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV), .CONST_VAL(CV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dff_const_pipe #(.WIDTH(W), .DEPTH(1), .RST_VAL(RV), .CONST_VAL(CV)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    assign bus1.en   = bus.en;
    assign bus1.mode = bus.mode;
    assign bus1.d    = bus.d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: history of injected words, newest first. Stage i is
    // the word injected i enabled edges ago.
    logic [3:0] hist [$];
    logic [3:0] m1_q;
    bit         m_valid = 0;

    always @(posedge clk) begin
        logic [3:0] s;
        s = bus.mode ? bus.d : CV;
        if (!reset) begin
            hist.delete();
            for (int i = 0; i < D; i++) hist.push_back(RV);
            m1_q    = RV;
            m_valid = 1;
        end else if (bus.en && m_valid) begin
            hist.push_front(s);
            void'(hist.pop_back());
            m1_q = s;
        end
    end

    function automatic int model_run();
        int n = 0;
        for (int i = 0; i < D; i++) begin
            if (hist[i] != hist[0]) break;
            n++;
        end
        return n;
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_q",        int'(bus.q),        int'(hist[D-1]));
            chk("model_settled",  int'(bus.settled),  int'(model_run() == D));
`ifdef DFF_CONST_PIPE_RUNLEN_EN
            chk("model_run_len",  int'(bus.run_len),  model_run());
            chk("d1_run_len",     int'(bus1.run_len), 1);
`endif
            chk("d1_q",           int'(bus1.q),       int'(m1_q));
            chk("d1_settled",     int'(bus1.settled), 1);
        end
    end

    task automatic step(input logic r, input logic e, input logic m, input logic [3:0] dv);
        reset    = r;
        bus.en   = e;
        bus.mode = m;
        bus.d    = dv;
        @(posedge clk);
        #1;
    endtask

    // Literal expectations; run_len is checked only when the port exists.
    task automatic lit(input string name, input logic [3:0] eq, input logic es, input int er);
        chk({name, "_q"},       int'(bus.q),       int'(eq));
        chk({name, "_settled"}, int'(bus.settled), int'(es));
`ifdef DFF_CONST_PIPE_RUNLEN_EN
        chk({name, "_run_len"}, int'(bus.run_len), er);
`else
        if (er < 0) $display("bad run_len literal");
`endif
    endtask

    initial begin
        logic [3:0] dseq [7];
        logic [3:0] qexp [7];
        int         rexp [7];
        dseq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4};
        qexp = '{4'hF, 4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
        rexp = '{1, 1, 1, 1, 2, 3, 4};

        reset = 1'b0; bus.en = 1'b1; bus.mode = 1'b1; bus.d = 4'hA;
        #1;

        // Reset flush ignores en/mode/d.
        step(1'b0, 1'b1, 1'b1, 4'hA);
        step(1'b0, 1'b1, 1'b1, 4'hA);
        lit("reset", 4'h0, 1'b1, 4);

        // Constant fill; d carries a decoy value that must be ignored.
        step(1'b1, 1'b1, 1'b0, 4'h5); lit("fill1", 4'h0, 1'b0, 1);
        chk("d1_fill1_q", int'(bus1.q), 'hF);
        step(1'b1, 1'b1, 1'b0, 4'h5); lit("fill2", 4'h0, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 4'h5); lit("fill3", 4'h0, 1'b0, 3);
        step(1'b1, 1'b1, 1'b0, 4'h5); lit("fill4", 4'hF, 1'b1, 4);

        // Data mode starting from the all-F pipe.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b1, dseq[i]);
            lit($sformatf("data%0d", i + 1), qexp[i], i == 6, rexp[i]);
        end

        // Stall: 2 enabled, 5 disabled (with changing inputs), 2 enabled.
        step(1'b0, 1'b1, 1'b0, 4'h0);
        lit("reset2", 4'h0, 1'b1, 4);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 4'(i + 3));
            lit($sformatf("stall%0d", i + 1), 4'h0, 1'b0, 2);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("stall_e8", 4'h0, 1'b0, 3);
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("stall_e9", 4'hF, 1'b1, 4);

        // Mid-flush reset, then a full refill.
        step(1'b0, 1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("mid1", 4'h0, 1'b0, 1);
        step(1'b0, 1'b1, 1'b0, 4'h0); lit("mid_rst", 4'h0, 1'b1, 4);
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("refill1", 4'h0, 1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("refill2", 4'h0, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("refill3", 4'h0, 1'b0, 3);
        step(1'b1, 1'b1, 1'b0, 4'h0); lit("refill4", 4'hF, 1'b1, 4);

        // Mode flip mid-stream: only the word entering s[0] changes.
        step(1'b1, 1'b1, 1'b1, 4'h9); lit("flip1", 4'hF, 1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 4'h9); lit("flip2", 4'hF, 1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 4'h9); lit("flip3", 4'hF, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 4'h9); lit("flip4", 4'h9, 1'b0, 3);
        step(1'b1, 1'b1, 1'b0, 4'h9); lit("flip5", 4'hF, 1'b1, 4);
        chk("d1_flip_q", int'(bus1.q), 'hF);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
